// File: rtl/pixel_plot_sink.sv
// -----------------------------------------------------------------------------
// pixel_plot_sink
//
// Consumer end of the plot interface used by the drawing datapaths. Plot
// requests (x, y, colour) are buffered in a small FIFO and each one becomes a
// single-cycle framebuffer write at linear address y*SCREEN_W + x. Pixels that
// fall outside the visible area are dropped and counted.
//
// Optional feature, enabled by defining FB_CLEAR_EN:
//   full-screen clear sweep requested through clear_req, writing CLEAR_COLOUR
//   to every visible address and pulsing clear_done afterwards. Without the
//   macro, clear_req is ignored and clear_done is held low.
//
// Ports
//   clock       system clock, all logic on the rising edge
//   reset       synchronous, active-high
//   plot        plot request strobe, accepted when plot && ready
//   x_in        pixel x (8 bits)
//   y_in        pixel y (7 bits)
//   colour_in   pixel colour (3 bits)
//   ready       FIFO can accept a request this cycle
//   fb_we       framebuffer write enable, one cycle per write
//   fb_addr     framebuffer write address (ADDR_W bits)
//   fb_data     framebuffer write data (3 bits)
//   drop_count  off-screen pixels dropped, saturates at 255
//   overflow    sticky: plot asserted while ready was low
//   clear_req   full-screen clear request (FB_CLEAR_EN only)
//   busy        FIFO non-empty, write in flight, or clear pending/active
//   clear_done  one-cycle pulse after the last clear write (FB_CLEAR_EN only)
// -----------------------------------------------------------------------------
module pixel_plot_sink #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned SCREEN_W     = 160,
   parameter int unsigned SCREEN_H     = 120,
   parameter int unsigned ADDR_W       = 15,
   parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              plot,
   input  logic [7:0]        x_in,
   input  logic [6:0]        y_in,
   input  logic [2:0]        colour_in,
   output logic              ready,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [2:0]        fb_data,
   output logic [7:0]        drop_count,
   output logic              overflow,
   input  logic              clear_req,
   output logic              busy,
   output logic              clear_done
);

   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned ENTRY_W = 18;

   // ---------------------------------------------------------------------------
   // Request FIFO
   // ---------------------------------------------------------------------------
   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W:0]     count;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;

   logic [ENTRY_W-1:0] pop_entry;
   logic [7:0]         pop_x;
   logic [6:0]         pop_y;
   logic [2:0]         pop_colour;
   logic               onscreen;
   logic [ADDR_W-1:0]  pix_addr;

   assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign push  = plot && ready;

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= {x_in, y_in, colour_in};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Head-of-FIFO decode: visibility test and linear address
   // ---------------------------------------------------------------------------
   assign pop_entry  = mem[rd_ptr];
   assign pop_x      = pop_entry[17:10];
   assign pop_y      = pop_entry[9:3];
   assign pop_colour = pop_entry[2:0];

   assign onscreen = (32'(pop_x) < SCREEN_W) && (32'(pop_y) < SCREEN_H);

   // For the 160-wide screen the multiply reduces to y*128 + y*32 + x.
   generate
      if (SCREEN_W == 160) begin : g_addr_shift
         assign pix_addr = (ADDR_W'(pop_y) << 7) + (ADDR_W'(pop_y) << 5) + ADDR_W'(pop_x);
      end else begin : g_addr_mul
         assign pix_addr = ADDR_W'(32'(pop_y) * SCREEN_W + 32'(pop_x));
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Drop counter and sticky overflow
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (pop && !onscreen && (drop_count != '1)) begin
            drop_count <= drop_count + 8'd1;
         end
         if (plot && !ready) begin
            overflow <= 1'b1;
         end
      end
   end

`ifdef FB_CLEAR_EN
   // ---------------------------------------------------------------------------
   // Write FSM with clear sweep
   // ---------------------------------------------------------------------------
   typedef enum logic {
      S_IDLE,
      S_CLEAR
   } state_t;

   localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(SCREEN_W * SCREEN_H - 1);

   state_t            state;
   logic              clear_pending;
   logic              clear_last;
   logic [ADDR_W-1:0] clear_cnt;

   assign pop   = !empty && (state == S_IDLE);
   assign ready = !full && (state != S_CLEAR) && !clear_pending;
   assign busy  = !empty || fb_we || clear_pending || (state == S_CLEAR);

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= S_IDLE;
         clear_pending <= 1'b0;
         clear_last    <= 1'b0;
         clear_cnt     <= '0;
         clear_done    <= 1'b0;
         fb_we         <= 1'b0;
         fb_addr       <= '0;
         fb_data       <= '0;
      end else begin
         fb_we      <= 1'b0;
         clear_last <= 1'b0;
         clear_done <= clear_last;

         // Requests during an active sweep merge into it.
         if (clear_req && (state != S_CLEAR)) begin
            clear_pending <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (pop) begin
                  if (onscreen) begin
                     fb_we   <= 1'b1;
                     fb_addr <= pix_addr;
                     fb_data <= pop_colour;
                  end
               end else if (clear_pending && !fb_we) begin
                  // FIFO drained and last pixel write retired: start sweep.
                  // Overrides a same-cycle clear_req so it merges.
                  state         <= S_CLEAR;
                  clear_pending <= 1'b0;
                  clear_cnt     <= '0;
               end
            end
            S_CLEAR: begin
               fb_we     <= 1'b1;
               fb_addr   <= clear_cnt;
               fb_data   <= CLEAR_COLOUR;
               clear_cnt <= clear_cnt + ADDR_W'(1);
               if (clear_cnt == CLEAR_LAST) begin
                  // clear_last delays clear_done by one cycle so it follows
                  // the cycle in which the final write is presented.
                  state      <= S_IDLE;
                  clear_last <= 1'b1;
               end
            end
         endcase
      end
   end
`else
   // ---------------------------------------------------------------------------
   // Write path without clear support
   // ---------------------------------------------------------------------------
   logic unused_clear_req;
   assign unused_clear_req = clear_req;

   assign pop        = !empty;
   assign ready      = !full;
   assign busy       = !empty || fb_we;
   assign clear_done = 1'b0;

   always_ff @(posedge clock) begin
      if (reset) begin
         fb_we   <= 1'b0;
         fb_addr <= '0;
         fb_data <= '0;
      end else begin
         fb_we <= 1'b0;
         if (pop && onscreen) begin
            fb_we   <= 1'b1;
            fb_addr <= pix_addr;
            fb_data <= pop_colour;
         end
      end
   end
`endif

endmodule
